ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 Parameter ALUOP_W, default 8, ALU opcode width.
REQ-004 Parameter ALUSEL_W, default 3, result-select width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-low; sampled on rising clk.
REQ-007 aluop_i  input  ALUOP_W  operation code.
REQ-008 alusel_i  input  ALUSEL_W  result class: LOGIC, SHIFT, ARITH, NOP.
REQ-009 reg1_i, reg2_i  input  DATA_W each  operands.
REQ-010 wd_i  input  REG_ADDR_W  destination address; wreg_i  input  1  write request.
REQ-011 flush_i  input  1  pipeline flush; aborts any divide in progress.
REQ-012 wdata_o  output  DATA_W  GPR write data; wd_o  output  REG_ADDR_W; wreg_o  output  1.
REQ-013 whilo_o  output  1  HI/LO write strobe; hi_o, lo_o  output  DATA_W each.
REQ-014 stallreq_o  output  1  request that upstream hold the instruction in EX.

Function
REQ-015 LOGIC ops OR, AND, XOR, NOR: combinational on reg1_i, reg2_i; result in the same cycle.
REQ-016 SHIFT ops SLL, SRL, SRA: shift reg2_i by reg1_i[log2(DATA_W)-1:0]; SRA sign-fills.
REQ-017 ARITH ops ADD, ADDU, SUB, SUBU, SLT, SLTU: same-cycle result; SLT/SLTU yield 1 or 0, zero-extended.
REQ-018 ADD/SUB signed overflow: wreg_o SHALL be 0 for that instruction; ADDU/SUBU never suppress.
REQ-019 Non-divide ops: wd_o = wd_i, wreg_o = wreg_i (except REQ-018), whilo_o = 0, stallreq_o = 0.
REQ-020 Unknown aluop_i or alusel_i NOP: wdata_o = 0; wd_o and wreg_o still pass through.
REQ-021 DIV (signed) and DIVU (unsigned): iterative radix-2 restoring divider; FSM states IDLE, BUSY, DONE.
REQ-022 IDLE, div op present, flush_i = 0: latch operands (magnitudes for DIV), counter = 0, go BUSY; stallreq_o = 1 in the same cycle.
REQ-023 BUSY: one quotient bit per cycle for exactly DATA_W cycles; stallreq_o = 1; then DONE.
REQ-024 DONE: stallreq_o = 0, whilo_o = 1, lo_o = quotient, hi_o = remainder for one cycle; next state IDLE.
REQ-025 Total divide latency SHALL be DATA_W+2 cycles from first presentation to the DONE cycle.
REQ-026 DIV sign fix: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-027 Divisor zero: IDLE goes directly to DONE (latency 2); lo_o = all ones, hi_o = dividend.
REQ-028 Upstream SHALL hold all inputs stable while stallreq_o = 1; the block does not recheck operands in BUSY.
REQ-029 flush_i = 1 in any state: next state IDLE, no whilo_o pulse, stallreq_o = 0 in that cycle.
REQ-030 Back-to-back divides: the second starts only in the cycle after DONE; DONE SHALL NOT re-accept.
REQ-031 Division-only outputs: whilo_o = 0, hi_o = 0, lo_o = 0 outside DONE; wreg_o follows wreg_i.

Reset
REQ-032 rst = 0 at a rising edge: FSM to IDLE, counter and divider registers to 0.
REQ-033 While rst = 0, all outputs SHALL be 0, regardless of inputs.
REQ-034 Reset during BUSY aborts the divide; no whilo_o pulse follows.

Structure
REQ-035 Opcode and select constants, the ZeroWord constant and the FSM state encoding SHALL live in the shared defines package.
REQ-036 The divider SHALL be a sub-module div_iter with start, signed, flush, busy and done pins; the result mux stays in ex_mdu.

Verification
REQ-037 OR 0xF0F0_0000 | 0x0000_0F0F -> wdata_o 0xF0F0_0F0F in the same cycle; stallreq_o 0.
REQ-038 ADD 0x7FFF_FFFF + 1 -> wreg_o 0; ADDU on the same operands -> wreg_o 1, wdata_o 0x8000_0000.
REQ-039 DIV -7 / 2 -> stallreq_o high 33 cycles; DONE gives lo 0xFFFF_FFFD, hi 0xFFFF_FFFF, whilo_o for 1 cycle.
REQ-040 DIVU 100 / 0 -> DONE on cycle 2; lo 0xFFFF_FFFF, hi 100.
REQ-041 DIVU started, flush_i pulsed in BUSY cycle 10 -> IDLE next cycle, no whilo_o; a new DIVU 9/3 then gives lo 3, hi 0.
REQ-042 SRA 4 on 0x8000_0000 -> 0xF800_0000; rst low in BUSY -> all outputs 0, IDLE after release.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared opcode, result-select, constant and divider-state definitions for the EX-stage MDU.
package ex_mdu_pkg;

  localparam logic [63:0] ZeroWord = 64'h0;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_mdu_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, signed via magnitudes.
//   state    | meaning
//   DIV_IDLE | waiting for start_i; latches operands on start
//   DIV_BUSY | DATA_W shift/subtract iterations
//   DIV_DONE | quotient/remainder valid for exactly one cycle
module div_iter
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, dsor_q;
  logic              qneg_q, rneg_q;

  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              ge;
  logic [DATA_W-1:0] rem_d, dd_mag, ds_mag;

  assign dd_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
  assign ds_mag = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

  // quo_q starts as the dividend and shifts its bits into the partial remainder
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign ge      = rem_sh >= {1'b0, dsor_q};
  assign rem_sub = rem_sh - {1'b0, dsor_q};
  assign rem_d   = ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsor_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            cnt_q <= '0;
            if (divisor_i == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend_i;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= DIV_DONE;
            end else begin
              quo_q   <= dd_mag;
              rem_q   <= '0;
              dsor_q  <= ds_mag;
              qneg_q  <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
              rneg_q  <= signed_i & dividend_i[DATA_W-1];
              state_q <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          quo_q <= {quo_q[DATA_W-2:0], ge};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= DIV_DONE;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o = !flush_i && ((state_q == DIV_IDLE && start_i) || state_q == DIV_BUSY);
  assign done_o = !flush_i && (state_q == DIV_DONE);
  assign quot_o = qneg_q ? -quo_q : quo_q;
  assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage ALU with logic/shift/arith result mux and an iterative divider driving HI/LO.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] sum, diff, result, div_quot, div_rem;
  logic [SH_W-1:0]   sh;
  logic              is_div, add_ovf, sub_ovf, suppress, div_busy, div_done;

  assign sh      = reg1_i[SH_W-1:0];
  assign sum     = reg1_i + reg2_i;
  assign diff    = reg1_i - reg2_i;
  assign add_ovf = (reg1_i[MSB] == reg2_i[MSB]) && (sum[MSB] != reg1_i[MSB]);
  assign sub_ovf = (reg1_i[MSB] != reg2_i[MSB]) && (diff[MSB] != reg1_i[MSB]);
  assign is_div  = (aluop_i == ALUOP_W'(OP_DIV)) || (aluop_i == ALUOP_W'(OP_DIVU));

  assign suppress = (alusel_i == ALUSEL_W'(SEL_ARITH)) &&
                    (((aluop_i == ALUOP_W'(OP_ADD)) && add_ovf) ||
                     ((aluop_i == ALUOP_W'(OP_SUB)) && sub_ovf));

  always_comb begin
    result = ZeroWord[DATA_W-1:0];
    case (alusel_i)
      ALUSEL_W'(SEL_LOGIC): begin
        case (aluop_i)
          ALUOP_W'(OP_OR):  result = reg1_i | reg2_i;
          ALUOP_W'(OP_AND): result = reg1_i & reg2_i;
          ALUOP_W'(OP_XOR): result = reg1_i ^ reg2_i;
          ALUOP_W'(OP_NOR): result = ~(reg1_i | reg2_i);
          default:          result = ZeroWord[DATA_W-1:0];
        endcase
      end
      ALUSEL_W'(SEL_SHIFT): begin
        case (aluop_i)
          ALUOP_W'(OP_SLL): result = reg2_i << sh;
          ALUOP_W'(OP_SRL): result = reg2_i >> sh;
          ALUOP_W'(OP_SRA): result = $unsigned($signed(reg2_i) >>> sh);
          default:          result = ZeroWord[DATA_W-1:0];
        endcase
      end
      ALUSEL_W'(SEL_ARITH): begin
        case (aluop_i)
          ALUOP_W'(OP_ADD), ALUOP_W'(OP_ADDU): result = sum;
          ALUOP_W'(OP_SUB), ALUOP_W'(OP_SUBU): result = diff;
          ALUOP_W'(OP_SLT):  result = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
          ALUOP_W'(OP_SLTU): result = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
          default:           result = ZeroWord[DATA_W-1:0];
        endcase
      end
      default: result = ZeroWord[DATA_W-1:0];
    endcase
  end

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (is_div),
    .signed_i   (aluop_i == ALUOP_W'(OP_DIV)),
    .flush_i    (flush_i),
    .dividend_i (reg1_i),
    .divisor_i  (reg2_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // reset forces every output low combinationally, independent of inputs
  assign wdata_o    = rst ? result : '0;
  assign wd_o       = rst ? wd_i : '0;
  assign wreg_o     = rst & wreg_i & ~suppress;
  assign stallreq_o = rst & div_busy;
  assign whilo_o    = rst & div_done;
  assign lo_o       = (rst && div_done) ? div_quot : '0;
  assign hi_o       = (rst && div_done) ? div_rem : '0;

endmodule
